// File: rtl/sr_cmd_gen_pkg.sv
// -----------------------------------------------------------------------------
// sr_cmd_pkg
// Shared types for the SR latch command generator: FSM states, command codes,
// synchroniser depth and the request-resolution helper.
// Optional feature macro: SR_CMD_PRIORITY_EN (simultaneous set/clear requests
// resolve to a clear command instead of being discarded).
// -----------------------------------------------------------------------------
package sr_cmd_pkg;

   localparam int SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DRIVE_SET = 2'd1,
      DRIVE_CLR = 2'd2,
      GUARD     = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      CMD_NONE = 2'd0,
      CMD_SET  = 2'd1,
      CMD_CLR  = 2'd2
   } cmd_e;

   // Map one cycle of request pulses onto a command. A collision either
   // cancels everything or, with the priority option, becomes a clear.
   function automatic cmd_e resolve_cmd(input logic set_req, input logic clr_req);
      cmd_e cmd;
      if (set_req && clr_req) begin
`ifdef SR_CMD_PRIORITY_EN
         cmd = CMD_CLR;
`else
         cmd = CMD_NONE;
`endif
      end else if (set_req) begin
         cmd = CMD_SET;
      end else if (clr_req) begin
         cmd = CMD_CLR;
      end else begin
         cmd = CMD_NONE;
      end
      return cmd;
   endfunction

endpackage

// File: rtl/sr_cmd_gen_if.sv
// -----------------------------------------------------------------------------
// sr_cmd_gen_if
// Request/command bundle between a requester and the SR command generator.
//   set_in, clr_in : raw asynchronous request lines (requester -> generator)
//   en, s, r       : latch enable / set / reset commands
//   busy           : generator is executing or guarding a command
//   conflict       : one-cycle collision status pulse
// Modports: master = requester / latch side, slave = sr_cmd_gen.
// -----------------------------------------------------------------------------
interface sr_cmd_gen_if;
   logic set_in;
   logic clr_in;
   logic en;
   logic s;
   logic r;
   logic busy;
   logic conflict;

   modport master (output set_in, output clr_in,
                   input  en, input s, input r, input busy, input conflict);
   modport slave  (input  set_in, input clr_in,
                   output en, output s, output r, output busy, output conflict);
endinterface

// File: rtl/sr_cmd_gen_debounce.sv
// -----------------------------------------------------------------------------
// sr_debounce
// Synchronises one raw request line, debounces it and emits a one-cycle
// request pulse on every 0->1 change of the debounced level.
//   clk, rst : system clock, asynchronous active-high reset
//   i_raw    : raw asynchronous input
//   o_req    : registered one-cycle request pulse
// -----------------------------------------------------------------------------
module sr_debounce
   import sr_cmd_pkg::*;
#(
   parameter int DB_CYCLES = 4,
   parameter int CNT_W     = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic i_raw,
   output logic o_req
);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_level;
   logic                   r_level_d;
   logic                   r_req;
   logic                   w_sync;

   assign w_sync = r_sync[SYNC_STAGES-1];
   assign o_req  = r_req;

   // Two-flop synchroniser for the asynchronous raw input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      end
   end

   // Debounce: the level flips only after DB_CYCLES consecutive differing samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_level <= 1'b0;
      end else if (w_sync == r_level) begin
         r_cnt <= '0;
      end else if (r_cnt == DB_LAST) begin
         r_level <= w_sync;
         r_cnt   <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Rising-edge detect on the debounced level; falling edges are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_level_d <= 1'b0;
         r_req     <= 1'b0;
      end else begin
         r_level_d <= r_level;
         r_req     <= r_level & ~r_level_d;
      end
   end

endmodule

// File: rtl/sr_cmd_gen.sv
// -----------------------------------------------------------------------------
// sr_cmd_gen
// Turns bouncy asynchronous set/clear request lines into clean, one-at-a-time
// gated SR latch commands. s and r are never high together and only change
// while en is low or on the edge where en itself changes.
//   clk  : system clock (rising edge)
//   rst  : asynchronous active-high reset
//   bus  : sr_cmd_gen_if.slave (set_in, clr_in in; en, s, r, busy, conflict out)
// Parameters: DB_CYCLES (debounce length), PULSE_LEN (en high time per
// command), CNT_W (counter width, must hold both).
// Optional feature macro: SR_CMD_PRIORITY_EN (collisions become clear commands).
// -----------------------------------------------------------------------------
module sr_cmd_gen
   import sr_cmd_pkg::*;
#(
   parameter int DB_CYCLES = 4,
   parameter int PULSE_LEN = 1,
   parameter int CNT_W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   sr_cmd_gen_if.slave  bus
);

   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);

   logic             w_set_req;
   logic             w_clr_req;
   logic             w_any_req;
   cmd_e             w_new_cmd;
   cmd_e             w_start;
   state_e           r_state;
   cmd_e             r_pend;
   logic [CNT_W-1:0] r_pcnt;
   logic             r_en;
   logic             r_s;
   logic             r_r;
   logic             r_busy;
   logic             r_conflict;

   sr_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_set (
      .clk   (clk),
      .rst   (rst),
      .i_raw (bus.set_in),
      .o_req (w_set_req)
   );

   sr_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_clr (
      .clk   (clk),
      .rst   (rst),
      .i_raw (bus.clr_in),
      .o_req (w_clr_req)
   );

   assign w_any_req = w_set_req | w_clr_req;
   assign w_new_cmd = resolve_cmd(w_set_req, w_clr_req);

   // Command to launch from IDLE: a fresh request beats the pending slot.
   always_comb begin
      w_start = CMD_NONE;
      if (w_any_req) begin
         w_start = w_new_cmd;
      end else begin
         w_start = r_pend;
      end
   end

   // Command FSM with pending slot and registered latch outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_pend     <= CMD_NONE;
         r_pcnt     <= '0;
         r_en       <= 1'b0;
         r_s        <= 1'b0;
         r_r        <= 1'b0;
         r_busy     <= 1'b0;
         r_conflict <= 1'b0;
      end else begin
         r_conflict <= w_set_req & w_clr_req;
         case (r_state)
            IDLE: begin
               // Slot is either consumed now or superseded by a new request.
               r_pend <= CMD_NONE;
               r_pcnt <= '0;
               case (w_start)
                  CMD_SET: begin
                     r_state <= DRIVE_SET;
                     r_en    <= 1'b1;
                     r_s     <= 1'b1;
                     r_r     <= 1'b0;
                     r_busy  <= 1'b1;
                  end
                  CMD_CLR: begin
                     r_state <= DRIVE_CLR;
                     r_en    <= 1'b1;
                     r_s     <= 1'b0;
                     r_r     <= 1'b1;
                     r_busy  <= 1'b1;
                  end
                  default: begin
                     r_state <= IDLE;
                     r_en    <= 1'b0;
                     r_s     <= 1'b0;
                     r_r     <= 1'b0;
                     r_busy  <= 1'b0;
                  end
               endcase
            end
            DRIVE_SET, DRIVE_CLR: begin
               if (w_any_req) begin
                  r_pend <= w_new_cmd;
               end else begin
                  r_pend <= r_pend;
               end
               if (r_pcnt == PULSE_LAST) begin
                  // en, s and r all drop together on this edge.
                  r_state <= GUARD;
                  r_pcnt  <= '0;
                  r_en    <= 1'b0;
                  r_s     <= 1'b0;
                  r_r     <= 1'b0;
               end else begin
                  r_pcnt <= r_pcnt + CNT_W'(1);
               end
            end
            GUARD: begin
               if (w_any_req) begin
                  r_pend <= w_new_cmd;
               end else begin
                  r_pend <= r_pend;
               end
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_pend  <= CMD_NONE;
               r_pcnt  <= '0;
               r_en    <= 1'b0;
               r_s     <= 1'b0;
               r_r     <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.en       = r_en;
   assign bus.s        = r_s;
   assign bus.r        = r_r;
   assign bus.busy     = r_busy;
   assign bus.conflict = r_conflict;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// -----------------------------------------------------------------------------
// tb_sr_cmd_gen
// Directed, cycle-indexed checks of sr_cmd_gen. Two instances: u_dut with
// PULSE_LEN=1 and u_dut3 with PULSE_LEN=3 (pending-slot scenarios). Inputs for
// edge c are driven 1 time unit after edge c-1; outputs are sampled 1 time
// unit after edge c. Honors SR_CMD_PRIORITY_EN for the collision case.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sr_cmd_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_total = 0;
   int   n_bad   = 0;

   sr_cmd_gen_if bus1();
   sr_cmd_gen_if bus3();

   sr_cmd_gen #(.DB_CYCLES(4), .PULSE_LEN(1), .CNT_W(8)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   sr_cmd_gen #(.DB_CYCLES(4), .PULSE_LEN(3), .CNT_W(8)) u_dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic en, input logic s, input logic r,
                       input logic busy, input logic conf);
      chk({tag, "_en"},   32'(bus1.en),       32'(en));
      chk({tag, "_s"},    32'(bus1.s),        32'(s));
      chk({tag, "_r"},    32'(bus1.r),        32'(r));
      chk({tag, "_busy"}, 32'(bus1.busy),     32'(busy));
      chk({tag, "_conf"}, 32'(bus1.conflict), 32'(conf));
   endtask

   task automatic chk3(input string tag, input logic en, input logic s, input logic r,
                       input logic busy, input logic conf);
      chk({tag, "_en"},   32'(bus3.en),       32'(en));
      chk({tag, "_s"},    32'(bus3.s),        32'(s));
      chk({tag, "_r"},    32'(bus3.r),        32'(r));
      chk({tag, "_busy"}, 32'(bus3.busy),     32'(busy));
      chk({tag, "_conf"}, 32'(bus3.conflict), 32'(conf));
   endtask

   function automatic logic in_rng(input int c, input int lo, input int hi);
      return (c >= lo) && (c <= hi);
   endfunction

   initial begin
      int   run1, run3, runs1, runs3, viol;
      logic pe1, ps1, pr1, pe3, ps3, pr3;
      logic rs, rc;

      bus1.set_in = 1'b0;
      bus1.clr_in = 1'b0;
      bus3.set_in = 1'b0;
      bus3.clr_in = 1'b0;

      // Reset state
      repeat (3) tick();
      chk1("rst1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk3("rst3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2 rst = 1'b0;
      repeat (8) tick();
      chk1("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Clean set held high: single command after edge 7, busy for 2 cycles
      for (int c = 0; c < 16; c++) begin
         bus1.set_in = 1'b1;
         tick();
         chk1($sformatf("clean_c%0d", c), c == 7, c == 7, 1'b0, in_rng(c, 7, 8), 1'b0);
      end
      bus1.set_in = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         chk1($sformatf("clean_rel_c%0d", c), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // Bounce shorter than DB_CYCLES: no command
      for (int c = 0; c < 20; c++) begin
         bus1.set_in = in_rng(c, 0, 2) || in_rng(c, 4, 6);
         tick();
         chk1($sformatf("bounce_c%0d", c), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // 6-cycle pulse: exactly one set command
      for (int c = 0; c < 20; c++) begin
         bus1.set_in = (c < 6);
         tick();
         chk1($sformatf("pulse6_c%0d", c), c == 7, c == 7, 1'b0, in_rng(c, 7, 8), 1'b0);
      end

      // Collision: both rise on the same edge
      for (int c = 0; c < 16; c++) begin
         bus1.set_in = 1'b1;
         bus1.clr_in = 1'b1;
         tick();
`ifdef SR_CMD_PRIORITY_EN
         chk1($sformatf("coll_c%0d", c), c == 7, 1'b0, c == 7, in_rng(c, 7, 8), c == 7);
`else
         chk1($sformatf("coll_c%0d", c), 1'b0, 1'b0, 1'b0, 1'b0, c == 7);
`endif
      end
      bus1.set_in = 1'b0;
      bus1.clr_in = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         chk1($sformatf("coll_rel_c%0d", c), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // Pending slot (PULSE_LEN=3): set at 7, clr pended at 8, then set and
      // clr both arrive busy (edges 15, 16) -> only the clr runs at 17.
      for (int c = 0; c < 30; c++) begin
         bus3.set_in = (c < 4) || (c >= 8);
         bus3.clr_in = in_rng(c, 1, 4) || (c >= 9);
         tick();
         chk3($sformatf("pend_c%0d", c),
              in_rng(c, 7, 9) || in_rng(c, 12, 14) || in_rng(c, 17, 19),
              in_rng(c, 7, 9),
              in_rng(c, 12, 14) || in_rng(c, 17, 19),
              in_rng(c, 7, 10) || in_rng(c, 12, 15) || in_rng(c, 17, 20),
              1'b0);
      end
      bus3.set_in = 1'b0;
      bus3.clr_in = 1'b0;
      repeat (12) tick();
      chk3("pend_rel", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset mid-command: outputs drop before the next clock edge
      for (int c = 0; c < 8; c++) begin
         bus1.set_in = 1'b1;
         tick();
      end
      chk1("rm_pre", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      #2 rst = 1'b1;
      bus1.set_in = 1'b0;
      #1;
      chk1("rm_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) tick();
      #2 rst = 1'b0;
      for (int c = 0; c < 15; c++) begin
         tick();
         chk1($sformatf("rm_post_c%0d", c), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // Invariant soak with random bouncy inputs on both instances
      run1 = 0; run3 = 0; runs1 = 0; runs3 = 0; viol = 0;
      pe1 = 1'b0; ps1 = 1'b0; pr1 = 1'b0;
      pe3 = 1'b0; ps3 = 1'b0; pr3 = 1'b0;
      rs = 1'b0; rc = 1'b0;
      for (int c = 0; c < 10040; c++) begin
         if (c < 10000) begin
            if ($urandom_range(0, 7) == 0) rs = ~rs;
            if ($urandom_range(0, 7) == 0) rc = ~rc;
         end else begin
            rs = 1'b0;
            rc = 1'b0;
         end
         bus1.set_in = rs;
         bus1.clr_in = rc;
         bus3.set_in = rc;
         bus3.clr_in = rs;
         tick();
         if (bus1.s && bus1.r) viol++;
         if (bus3.s && bus3.r) viol++;
         if (bus1.en && !(bus1.s ^ bus1.r)) viol++;
         if (bus3.en && !(bus3.s ^ bus3.r)) viol++;
         if (((bus1.s != ps1) || (bus1.r != pr1)) && pe1 && bus1.en) viol++;
         if (((bus3.s != ps3) || (bus3.r != pr3)) && pe3 && bus3.en) viol++;
         if (bus1.en) begin
            run1++;
         end else begin
            if (run1 != 0) begin
               chk("soak1_len", 32'(run1), 32'd1);
               runs1++;
            end
            run1 = 0;
         end
         if (bus3.en) begin
            run3++;
         end else begin
            if (run3 != 0) begin
               chk("soak3_len", 32'(run3), 32'd3);
               runs3++;
            end
            run3 = 0;
         end
         pe1 = bus1.en; ps1 = bus1.s; pr1 = bus1.r;
         pe3 = bus3.en; ps3 = bus3.s; pr3 = bus3.r;
      end
      chk("soak_viol", 32'(viol), 32'd0);
      chk("soak1_cmds", 32'(runs1 > 0), 32'd1);
      chk("soak3_cmds", 32'(runs3 > 0), 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/sr_cmd_gen.md
Name: sr_cmd_gen

Overview:
- Upstream command stage for the gated SR latch.
- Turns two raw, asynchronous, bouncy request lines (set_in, clr_in) into clean, synchronised, one-at-a-time latch commands on en/s/r.
- Guarantees that s=1 and r=1 are never driven together, so the latch never sees its forbidden input.
- Also guarantees en is low whenever s/r change.

Parameters:
- DB_CYCLES, 4, number of consecutive stable synchronised samples required before a debounced level changes (min 1).
- PULSE_LEN, 1, number of cycles en/s or en/r stay asserted per command (min 1).
- CNT_W, 8, width of the debounce and pulse counters. Must hold max(DB_CYCLES, PULSE_LEN).

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- set_in  input  1  raw set request, asynchronous, may bounce.
- clr_in  input  1  raw clear request, asynchronous, may bounce.
- en  output  1  latch enable, registered.
- s  output  1  latch set, registered.
- r  output  1  latch reset, registered.
- busy  output  1  high while state is not IDLE.
- conflict  output  1  one-cycle pulse when set and clear requests collide.

Behaviour:
- Reset (asynchronous, active-high):
  - en=s=r=busy=conflict=0.
  - Synchroniser flops, debounced levels, counters and pending slot are cleared.
  - State = IDLE.
  - Reset mid-command drops en/s/r to 0 immediately; the command is lost.
- Synchronisation: each input passes through a 2-flop synchroniser.
- Debounce, per input:
  - The counter increments each edge on which the synchronised value differs from the debounced level.
  - The counter clears on any edge where they match.
  - When the count reaches DB_CYCLES, the debounced level flips and the counter clears.
  - Bounces shorter than DB_CYCLES produce no command.
- Request generation: a 0->1 flip of a debounced level produces a one-cycle request (set_req / clr_req). 1->0 flips produce nothing.
- Input held high across reset release: the debounced level starts at 0, so one request is generated after debounce.
- FSM states:
  - IDLE: outputs en=s=r=0.
    - set_req only -> DRIVE_SET.
    - clr_req only -> DRIVE_CLR.
    - Both in the same cycle -> conflict=1 for one cycle, stay IDLE.
    - Otherwise, if a pending command is stored, consume it and go to the matching DRIVE state.
  - DRIVE_SET: en=1, s=1, r=0 for exactly PULSE_LEN cycles, then GUARD.
  - DRIVE_CLR: en=1, s=0, r=1 for exactly PULSE_LEN cycles, then GUARD.
  - GUARD: en=s=r=0 for exactly 1 cycle, then IDLE.
- Requests while busy (DRIVE_*/GUARD):
  - Stored in a one-entry pending slot; the last single request wins.
  - Both requests in the same cycle clear the slot and pulse conflict.
- Latency: raw rising edge sampled at edge k -> s (or r) and en first high after edge k+DB_CYCLES+3.
- Invariants:
  - s&r is never 1.
  - s and r change only while en=0, or on the same edge as en rises or falls.
  - en high for exactly PULSE_LEN consecutive cycles per command.

Optional Feature:
- Macro: SR_CMD_PRIORITY_EN.
- Defined: simultaneous set_req/clr_req, in IDLE or while busy, resolve as a clear command (DRIVE_CLR or pending=CLR). conflict still pulses for one cycle as a status flag.
- Undefined: both requests are discarded as described above.

Decomposition:
- Package sr_cmd_pkg holds:
  - state enum: IDLE, DRIVE_SET, DRIVE_CLR, GUARD.
  - command enum: CMD_NONE, CMD_SET, CMD_CLR.
  - localparam SYNC_STAGES=2.
- Sub-module sr_debounce (synchroniser, debounce counter, rising-edge request output), instantiated twice. sr_cmd_gen holds the FSM and pending slot.

Test Plan (DB_CYCLES=4, PULSE_LEN=1 unless noted):
- Clean set: set_in 0->1 sampled at edge 0 and held -> en=s=1, r=0 during cycle after edge 7 only; then GUARD; busy high 2 cycles; no second command while held.
- Bounce rejection: set_in high 3 cycles, low 1, high 3, low -> no en pulse ever. A following 6-cycle high pulse -> exactly one set command.
- Collision: set_in and clr_in rise on the same edge -> conflict pulse after edge 7, en never rises. With SR_CMD_PRIORITY_EN: en=r=1 after edge 7, s=0, conflict=1.
- Pending (PULSE_LEN=3):
  - set command in progress; clr_in rise debounced during DRIVE_SET -> 3 cycles s, 1 guard, then 3 cycles r.
  - A set then clr, both arriving while busy -> only the clr is executed.
- Reset mid-command: assert rst asynchronously during DRIVE_SET -> en=s=0 before the next clk edge. After release with inputs low -> outputs stay 0.
- Invariant soak: 10k cycles of random bouncy set_in/clr_in -> s&r never 1, every en run length == PULSE_LEN, at least one idle cycle between en runs.
